// File: rtl/neural_fx_pkg.sv
// Shared Q6.10 fixed-point definitions for the sigmoid forward/backward and update stages.
package neural_fx_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;
  localparam int ONE    = 1 << FRAC_W;
  localparam int UNIT_W = FRAC_W + 1;   // holds 0..ONE inclusive

  localparam logic signed [DATA_W-1:0] ONE_Q = DATA_W'(ONE);

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

  // Clamp a signed Q6.10 value into the unit interval [0, ONE].
  function automatic logic [UNIT_W-1:0] clamp_unit(input logic signed [DATA_W-1:0] v);
    if (v < 0)          return '0;
    else if (v > ONE_Q) return UNIT_W'(ONE);
    else                return v[UNIT_W-1:0];
  endfunction
endpackage

// File: rtl/shift_add_mul.sv
// Iterative LSB-first shift-add multiplier: signed multiplicand times unsigned multiplier.
module shift_add_mul #(
  parameter int MC_W  = 16,
  parameter int MP_W  = 11,
  parameter int CNT_W = 4,
  parameter int ACC_W = MC_W + MP_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [MC_W-1:0]  mcand,
  input  logic        [MP_W-1:0]  mplier,
  input  logic        [CNT_W-1:0] iters,
  output logic                    busy,
  output logic                    done,
  output logic signed [ACC_W-1:0] prod_nxt
);
  logic signed [ACC_W-1:0] acc, mc, addend;
  logic        [MP_W-1:0]  mp;
  logic        [CNT_W-1:0] cnt;

  // prod_nxt is the accumulator value after this cycle's iteration, so the
  // caller can use the final product on the same edge the last step lands.
  always_comb begin
    addend   = mp[0] ? mc : '0;
    prod_nxt = acc + addend;
    done     = busy && (cnt == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      mc   <= '0;
      mp   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      acc  <= '0;
      mc   <= {{(ACC_W-MC_W){mcand[MC_W-1]}}, mcand};
      mp   <= mplier;
      cnt  <= iters;
      busy <= (iters != '0);
    end else if (busy) begin
      acc <= prod_nxt;
      mc  <= mc <<< 1;
      mp  <= mp >> 1;
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/sigmoid_backprop.sv
// Sigmoid backward pass: delta = err * y * (1 - y), using one time-shared shift-add multiplier.
module sigmoid_backprop
  import neural_fx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] delta
);
  localparam int ACC_W = DATA_W + UNIT_W;
  localparam int CNT_W = 4;
  localparam int D_W   = 9;   // y*(1-y) in Q.10 never exceeds 256

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] err_q;
  logic        [UNIT_W-1:0] y_c, omy;
  logic                     mul_start, mul_busy, mul_done;
  logic signed [DATA_W-1:0] mul_mc;
  logic        [UNIT_W-1:0] mul_mp;
  logic        [CNT_W-1:0]  mul_iters;
  logic signed [ACC_W-1:0]  p_nxt;
  logic                     unused_bits;

  assign y_c       = clamp_unit(y);
  assign omy       = UNIT_W'(ONE) - y_c;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    mul_mc    = '0;
    mul_mp    = '0;
    mul_iters = '0;
    case (state)
      IDLE: if (in_valid) begin
        mul_start = 1'b1;
        mul_mc    = DATA_W'(y_c);
        mul_mp    = omy;
        mul_iters = CNT_W'(UNIT_W);
        state_nxt = MUL1;
      end
      // Second pass starts on the same edge the first one finishes.
      MUL1: if (mul_done) begin
        mul_start = 1'b1;
        mul_mc    = err_q;
        mul_mp    = UNIT_W'(p_nxt[FRAC_W +: D_W]);
        mul_iters = CNT_W'(D_W);
        state_nxt = MUL2;
      end
      MUL2: if (mul_done)  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      err_q <= '0;
      delta <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) err_q <= err;
      // Taking bits above FRAC_W of the signed product is a floor shift.
      if (state == MUL2 && mul_done) delta <= p_nxt[FRAC_W +: DATA_W];
    end
  end

  shift_add_mul #(
    .MC_W (DATA_W),
    .MP_W (UNIT_W),
    .CNT_W(CNT_W),
    .ACC_W(ACC_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .mcand   (mul_mc),
    .mplier  (mul_mp),
    .iters   (mul_iters),
    .busy    (mul_busy),
    .done    (mul_done),
    .prod_nxt(p_nxt)
  );

  assign unused_bits = ^{p_nxt[ACC_W-1], p_nxt[FRAC_W-1:0], mul_busy};
endmodule

// File: tb/tb_sigmoid_backprop.sv
// Scoreboard bench for sigmoid_backprop: driver pushes model results, negedge monitor checks outputs.
module tb_sigmoid_backprop;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready;
  logic [15:0] y = '0, err = '0, delta;

  int checks = 0, errors = 0, cyc = 0;
  logic [15:0] exp_q[$];
  int          lat_q[$];
  logic        rand_rdy = 1'b0, force_rdy = 1'b1;
  logic        prev_ov = 1'b0, prev_hs = 1'b0;
  logic [15:0] held;

  sigmoid_backprop dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .err(err), .out_valid(out_valid), .out_ready(out_ready), .delta(delta)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // delta = floor(err * floor(yc*(1-yc)) ) with yc = y clamped to [0,1], all in Q6.10
  function automatic logic [15:0] model(input logic [15:0] yv, input logic [15:0] ev);
    int ys, yc, d, p, q;
    ys = int'($signed(yv));
    yc = (ys < 0) ? 0 : ((ys > 1024) ? 1024 : ys);
    d  = (yc * (1024 - yc)) / 1024;
    p  = int'($signed(ev)) * d;
    q  = (p >= 0) ? p / 1024 : -((-p + 1023) / 1024);
    return q[15:0];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) chk("in_ready_after_xfer", {31'd0, in_ready}, 32'd1);
      if (out_valid) begin
        chk("in_ready_low_while_valid", {31'd0, in_ready}, 32'd0);
        if (!prev_ov) begin
          if (lat_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output actual=%h required=none", delta);
          end else chk("latency", cyc - lat_q.pop_front(), 32'd20);
          held = delta;
        end else chk("delta_stable", {16'd0, delta}, {16'd0, held});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_transfer actual=%h required=none", delta);
        end else chk("delta", {16'd0, delta}, {16'd0, exp_q.pop_front()});
      end
      prev_hs = out_valid && out_ready;
      prev_ov = out_valid && !out_ready;
    end
  end

  task automatic send(input logic [15:0] yv, input logic [15:0] ev);
    int n = 0;
    in_valid = 1'b1; y = yv; err = ev;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=0 required=1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    exp_q.push_back(model(yv, ev));
    lat_q.push_back(cyc);
    in_valid = 1'b0;
    y = 16'($urandom); err = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    #1;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete(); lat_q.delete();
    end
  endtask

  logic [15:0] dy[12] = '{16'h0200, 16'h0100, 16'h0200, 16'h0200, 16'h0200, 16'h0000,
                          16'h0400, 16'hFC00, 16'h0800, 16'h0200, 16'h0333, 16'h03FF};
  logic [15:0] de[12] = '{16'h0400, 16'h0400, 16'hFC00, 16'hFFFF, 16'h0001, 16'h7FFF,
                          16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_delta", {16'd0, delta}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed values; y/err are also scrambled during MUL1 after each accept
    for (int i = 0; i < 12; i++) begin
      send(dy[i], de[i]);
      repeat (5) begin @(posedge clk); #1; y = 16'($urandom); err = 16'($urandom); end
      drain();
    end

    // Hold off the output while offering new inputs
    force_rdy = 1'b0;
    @(posedge clk); #1;
    send(16'h0100, 16'hFC00);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      if (!out_valid) begin
        checks++; errors++;
        $display("FAIL hold_wait actual=0 required=1");
      end
    end
    repeat (10) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); y = 16'($urandom); err = 16'($urandom);
    end
    in_valid = 1'b0;
    chk("held_out_valid", {31'd0, out_valid}, 32'd1);
    force_rdy = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("no_stray_accept", {31'd0, out_valid}, 32'd0);

    // Reset during MUL2
    send(16'h0200, 16'h0400);
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_delta", {16'd0, delta}, 32'd0);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0200, 16'h0400);
    drain();

    // Random operands under random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ry;
      ry = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1024));
      send(ry, 16'($urandom));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    drain();
    rand_rdy = 1'b0;
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sigmoid_backprop.md
# sigmoid_backprop

Backward-pass companion to the forward `sigmoid` activation. It takes a stored sigmoid output `y` and an incoming error `err`, both signed Q6.10. It returns the local gradient `delta = err * y * (1 - y)`. The block sits between the error-propagation stage and the weight-update stage. It uses an iterative shift-add datapath with valid/ready handshakes on both sides.

## Interface
- `DATA_W`, 16, word width (signed fixed point)
- `FRAC_W`, 10, fractional bits (Q6.10); `ONE = 1 << FRAC_W`
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `y`/`err` valid
- `in_ready`  out  1  block can accept an operand pair
- `y`  in  DATA_W  forward sigmoid output, Q6.10
- `err`  in  DATA_W  signed error term, Q6.10
- `out_valid`  out  1  `delta` valid
- `out_ready`  in  1  downstream accepts `delta`
- `delta`  out  DATA_W  signed gradient, Q6.10

## Operation
- **FSM states:** IDLE, MUL1, MUL2, DONE.
- **IDLE:** `in_ready` = 1. On `in_valid & in_ready`:
  - Latch `err`.
  - Clamp `y` to [0, ONE]: negative → 0; above ONE → ONE.
  - Form `omy = ONE - y_c`, unsigned 11 bits.
  - Go to MUL1.
- **MUL1:** 11 shift-add iterations computing `p1 = y_c * omy`, unsigned 22 bits.
  - `d = p1 >> FRAC_W`, truncated; range 0..256.
  - Go to MUL2.
- **MUL2:** 9 iterations over the bits of `d`, computing `p2 = err * d`, signed 25 bits.
  - `delta = p2 >>> FRAC_W`, an arithmetic shift that floors toward −∞.
  - `|delta| <= |err|/4`, so the result always fits DATA_W; no saturation logic.
  - Go to DONE.
- **DONE:** `out_valid` = 1. `delta` is held stable until `out_valid & out_ready`, then go to IDLE.
- `in_ready` is 0 in every state except IDLE, so there is no accept in the same cycle as an output handshake.
- Inputs are sampled only at the accept edge. Changes on `y`/`err` afterwards are ignored.
- **Reset values:** state = IDLE, `in_ready` = 1, `out_valid` = 0, `delta` = 0, all accumulators = 0.
- **Reset mid-operation** (any state): the in-flight result is discarded and `out_valid` drops asynchronously.
- **Boundary outputs:** `y_c` = 0 or `y_c` = ONE gives `delta` = 0 regardless of `err`.

## Timing
- **Accept:** edge E0.
- **MUL1:** edges E1..E11; E11 moves to MUL2.
- **MUL2:** edges E12..E20; E20 moves to DONE.
- **Output:** `out_valid` rises after E20, giving a latency of 20 cycles.
- **Back-pressure:** if `out_ready` is held high, `in_ready` returns the cycle after E21. Minimum initiation interval is 22 cycles.
- **Back-pressure held off:** while `out_ready` = 0 the block stays in DONE indefinitely, and `delta`/`out_valid` are unchanged.
- `out_valid` and `in_ready` are never high together.

## Structure
- **Shared package `neural_fx_pkg`** holds:
  - `DATA_W`, `FRAC_W`, `ONE`;
  - the Q6.10 clamp helper;
  - the state enum (IDLE/MUL1/MUL2/DONE).
  
  The forward sigmoid and the update stage reuse these.
- **One sub-module `shift_add_mul`:**
  - signed 16-bit multiplicand, unsigned 11-bit multiplier;
  - `start` input and iteration-count input;
  - `busy`/`done` outputs.
  
  It is instantiated once and time-multiplexed across MUL1 (11 iterations) and MUL2 (9 iterations). The FSM and operand muxing stay in `sigmoid_backprop`.

## Test plan
- `y` = 0x0200 (0.5), `err` = 0x0400 (1.0) → `delta` = 0x0100 (0.25), `out_valid` exactly 20 cycles after accept.
- `y` = 0x0100 (0.25), `err` = 0x0400 → `d` = 192, `delta` = 0x00C0. Then `err` = 0xFC00 (−1.0) with `y` = 0x0200 → `delta` = 0xFF00.
- Floor rounding: `y` = 0x0200, `err` = 0xFFFF → `delta` = 0xFFFF; `err` = 0x0001 → `delta` = 0x0000.
- Clamp:
  - `y` = 0x0000, 0x0400, 0xFC00 (−1.0), or 0x0800 (2.0), with `err` = 0x7FFF → `delta` = 0x0000 for each;
  - `y` = 0x0200, `err` = 0x7FFF → 0x1FFF (no overflow).
- Handshake:
  - `out_ready` held low 10 cycles → `delta` stable, `in_ready` = 0 throughout, and the `in_valid` pulses offered meanwhile are not accepted;
  - release → single output transfer, `in_ready` high the next cycle;
  - `y`/`err` toggled during MUL1 do not change the result.
- Assert `rst_n` low during MUL2 → `out_valid` = 0 and `in_ready` = 1 immediately. After release, a fresh `y` = 0x0200, `err` = 0x0400 yields 0x0100 with 20-cycle latency.
